// File: rtl/opb_cfg_master.sv
// Single-beat OPB master that turns a cmd/rsp handshake into bus reads and writes.
// Optional per-outcome statistics counters are enabled by defining OPB_CFG_MASTER_STATS_EN.
module opb_cfg_master #(
  parameter logic [31:0] C_BASEADDR  = 32'h0000_0000,
  parameter int unsigned C_TIMEOUT   = 16,
  parameter int unsigned C_MAX_RETRY = 3
) (
  input  logic        OPB_Clk,
  input  logic        OPB_Rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rnw,
  input  logic [29:0] cmd_addr,
  input  logic [3:0]  cmd_be,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_status,
  output logic        M_request,
  input  logic        OPB_MGrant,
  output logic        M_select,
  output logic        M_RNW,
  output logic [0:31] M_ABus,
  output logic [0:3]  M_BE,
  output logic [0:31] M_DBus,
  output logic        M_seqAddr,
  input  logic [0:31] OPB_DBus,
  input  logic        OPB_xferAck,
  input  logic        OPB_errAck,
  input  logic        OPB_retry,
  input  logic        OPB_toutSup
`ifdef OPB_CFG_MASTER_STATS_EN
  ,
  output logic [15:0] stat_xfers,
  output logic [15:0] stat_errs,
  output logic [15:0] stat_touts,
  output logic [15:0] stat_retries
`endif
);

  localparam int unsigned TW = $clog2(C_TIMEOUT + 1);
  localparam int unsigned RW = $clog2(C_MAX_RETRY + 1);
  localparam logic [TW-1:0] ToutLast = TW'(C_TIMEOUT - 1);
  localparam logic [RW-1:0] RetryMax = RW'(C_MAX_RETRY);

  typedef enum logic [1:0] {StIdle, StReq, StXfer, StResp} state_e;

  state_e        state_q, state_d;
  logic          rnw_q;
  logic [29:0]   addr_q;
  logic [3:0]    be_q;
  logic [31:0]   wdata_q;
  logic [TW-1:0] tout_q, tout_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [1:0]    status_q, status_d;
  logic          accept;
  logic          sel_d;
  logic [0:3]    be_bus;

  assign cmd_ready  = (state_q == StIdle);
  assign rsp_valid  = (state_q == StResp);
  assign rsp_rdata  = rdata_q;
  assign rsp_status = status_q;
  assign M_seqAddr  = 1'b0;
  assign sel_d      = (state_d == StXfer);

  // Byte enables keep their index on the bus (cmd_be[0] drives M_BE[0]).
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      be_bus[i] = be_q[i];
    end
  end

  always_comb begin
    state_d  = state_q;
    tout_d   = tout_q;
    retry_d  = retry_q;
    rdata_d  = rdata_q;
    status_d = status_q;
    accept   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          accept  = 1'b1;
          retry_d = '0;
          state_d = StReq;
        end
      end
      StReq: begin
        if (OPB_MGrant) begin
          tout_d  = '0;
          state_d = StXfer;
        end
      end
      StXfer: begin
        if (OPB_errAck) begin
          status_d = 2'b01;
          rdata_d  = '0;
          state_d  = StResp;
        end else if (OPB_xferAck) begin
          status_d = 2'b00;
          rdata_d  = rnw_q ? 32'(OPB_DBus) : 32'h0;
          state_d  = StResp;
        end else if (OPB_retry) begin
          retry_d = retry_q + 1'b1;
          tout_d  = '0;
          if (retry_d == RetryMax) begin
            status_d = 2'b11;
            rdata_d  = '0;
            state_d  = StResp;
          end else begin
            state_d = StReq;
          end
        end else if (!OPB_toutSup) begin
          if (tout_q == ToutLast) begin
            status_d = 2'b10;
            rdata_d  = '0;
            state_d  = StResp;
          end else begin
            tout_d = tout_q + 1'b1;
          end
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Bus outputs are registered from the next state so they line up with it.
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      state_q   <= StIdle;
      rnw_q     <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      tout_q    <= '0;
      retry_q   <= '0;
      rdata_q   <= '0;
      status_q  <= '0;
      M_request <= 1'b0;
      M_select  <= 1'b0;
      M_RNW     <= 1'b0;
      M_ABus    <= '0;
      M_BE      <= '0;
      M_DBus    <= '0;
    end else begin
      state_q  <= state_d;
      tout_q   <= tout_d;
      retry_q  <= retry_d;
      rdata_q  <= rdata_d;
      status_q <= status_d;
      if (accept) begin
        rnw_q   <= cmd_rnw;
        addr_q  <= cmd_addr;
        be_q    <= cmd_be;
        wdata_q <= cmd_wdata;
      end
      M_request <= (state_d == StReq);
      M_select  <= sel_d;
      M_RNW     <= sel_d && rnw_q;
      M_ABus    <= sel_d ? (C_BASEADDR + {addr_q, 2'b00}) : 32'h0;
      M_BE      <= sel_d ? be_bus : 4'h0;
      M_DBus    <= (sel_d && !rnw_q) ? wdata_q : 32'h0;
    end
  end

`ifdef OPB_CFG_MASTER_STATS_EN
  logic in_xfer, ev_err, ev_ok, ev_retry, ev_tout;

  assign in_xfer  = (state_q == StXfer);
  assign ev_err   = in_xfer && OPB_errAck;
  assign ev_ok    = in_xfer && !OPB_errAck && OPB_xferAck;
  assign ev_retry = in_xfer && !OPB_errAck && !OPB_xferAck && OPB_retry;
  assign ev_tout  = in_xfer && !OPB_errAck && !OPB_xferAck && !OPB_retry && !OPB_toutSup &&
                    (tout_q == ToutLast);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      stat_xfers   <= '0;
      stat_errs    <= '0;
      stat_touts   <= '0;
      stat_retries <= '0;
    end else begin
      if (ev_ok)    stat_xfers   <= sat_inc(stat_xfers);
      if (ev_err)   stat_errs    <= sat_inc(stat_errs);
      if (ev_tout)  stat_touts   <= sat_inc(stat_touts);
      if (ev_retry) stat_retries <= sat_inc(stat_retries);
    end
  end
`endif

endmodule
